// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over a fixed
// window of clk_in cycles and reports the distance from first to last edge.
module freq_meter #(
    parameter int GATE_CYCLES = 100,
    parameter int CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] span
);

    localparam int               GATE_EFF = (GATE_CYCLES < 2) ? 2 : GATE_CYCLES;
    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GATE_EFF - 1);

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t           state, state_nx;
    logic             s1, s2, s3;
    logic             rise;
    logic             gate_end;
    logic [CNT_W-1:0] g, cnt, first, last;
    logic [CNT_W-1:0] cnt_nx, first_nx, last_nx;

    function automatic logic [CNT_W-1:0] calc_span(input logic [CNT_W-1:0] n,
                                                   input logic [CNT_W-1:0] lo,
                                                   input logic [CNT_W-1:0] hi);
        return (n >= CNT_W'(2)) ? (hi - lo) : '0;
    endfunction

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign gate_end = (state == GATE) && (g == G_LAST);
    assign busy     = (state == GATE);
    assign done     = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = GATE;
            GATE:    if (gate_end) state_nx = DONE;
            DONE:    state_nx = start ? GATE : IDLE;
            default: state_nx = IDLE;
        endcase
        if (clr) state_nx = IDLE;
    end

    // Counter values including the current cycle's edge, so an edge in the
    // final gate cycle still lands in the captured result.
    always_comb begin
        cnt_nx   = cnt;
        first_nx = first;
        last_nx  = last;
        if (state == GATE && rise) begin
            cnt_nx  = cnt + CNT_W'(1);
            last_nx = g;
            if (cnt == '0) first_nx = g;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            g        <= '0;
            cnt      <= '0;
            first    <= '0;
            last     <= '0;
            edge_cnt <= '0;
            span     <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == GATE && state != GATE) begin
                g     <= '0;
                cnt   <= '0;
                first <= '0;
                last  <= '0;
            end else if (state == GATE) begin
                g     <= g + CNT_W'(1);
                cnt   <= cnt_nx;
                first <= first_nx;
                last  <= last_nx;
            end
            if (state_nx == DONE) begin
                edge_cnt <= cnt_nx;
                span     <= calc_span(cnt_nx, first_nx, last_nx);
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: expected results are queued at start and
// checked when done pulses; gate length, abort, back-to-back and reset checked inline.
module tb_freq_meter;

    localparam int GATE = 100;
    localparam int CW   = 16;

    logic          clk_in = 1'b0;
    logic          rst    = 1'b0;
    logic          sig_in = 1'b0;
    logic          start  = 1'b0;
    logic          clr    = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] edge_cnt;
    logic [CW-1:0] span;

    typedef struct {
        int edges;
        int lo;
        int hi;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   done_at[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc_n      = 0;
    int   mode       = 0;
    int   ph         = 0;
    int   acc        = 0;
    int   ratio;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(CW)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .sig_in   (sig_in),
        .start    (start),
        .clr      (clr),
        .busy     (busy),
        .done     (done),
        .edge_cnt (edge_cnt),
        .span     (span)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (rst === 1'b1 && done === 1'b1) begin
            done_at.push_back(cyc_n);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                cur = sb.pop_front();
                check("edge_cnt", 32'(edge_cnt), cur.edges);
                if (cur.lo == cur.hi) begin
                    check("span", 32'(span), cur.lo);
                end else begin
                    check($sformatf("span_range(span=%0d)", span),
                          32'(span >= cur.lo && span <= cur.hi), 32'd1);
                    ratio = (int'(span) * 1000) / (int'(edge_cnt) - 1);
                    check($sformatf("ratio_x1000(%0d)", ratio),
                          32'(ratio >= 2470 && ratio <= 2530), 32'd1);
                end
            end
        end
    end

    // Advance one clock and update sig_in for the selected source pattern.
    task automatic step();
        @(posedge clk_in);
        #1;
        case (mode)
            0: sig_in = 1'b0;
            1: begin
                ph     = (ph + 1) % 4;
                sig_in = (ph >= 2);
            end
            2: begin
                acc += 2;
                if (acc >= 5) begin
                    acc -= 5;
                    sig_in = 1'b1;
                end else begin
                    sig_in = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic push_exp(input int e, input int lo, input int hi);
        exp_t x;
        x.edges = e;
        x.lo    = lo;
        x.hi    = hi;
        sb.push_back(x);
    endtask

    // Starts a window and counts busy cycles; optional mid-window pulse, start or clr.
    task automatic run_window(input int pulse_at, input int start_at, input int abort_at,
                              output int n);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            if (pulse_at >= 0 && n == pulse_at)     sig_in = 1'b1;
            if (pulse_at >= 0 && n == pulse_at + 2) sig_in = 1'b0;
            if (n == start_at) start = 1'b1;
            if (n == abort_at) clr = 1'b1;
            n++;
            step();
            start = 1'b0;
            clr   = 1'b0;
        end
    endtask

    initial begin
        int n;
        int d0;

        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("rst_span", 32'(span), 32'd0);
        rst = 1'b1;
        repeat (2) step();

        mode = 1;
        repeat (8) step();
        push_exp(25, 96, 96);
        run_window(-1, -1, -1, n);
        check("div4_gate_len", n, GATE);
        check("div4_done", 32'(done), 32'd1);
        step();
        check("div4_done_width", 32'(done), 32'd0);

        mode = 2;
        acc  = 0;
        repeat (5) step();
        push_exp(40, 97, 98);
        run_window(-1, -1, -1, n);
        check("frac_gate_len", n, GATE);
        step();

        mode = 0;
        repeat (4) step();
        push_exp(0, 0, 0);
        run_window(-1, -1, -1, n);
        check("none_gate_len", n, GATE);
        step();

        mode = 3;
        sig_in = 1'b0;
        push_exp(1, 0, 0);
        run_window(40, -1, -1, n);
        check("single_gate_len", n, GATE);
        step();

        mode = 1;
        repeat (4) step();
        run_window(-1, -1, 50, n);
        check("abort_len", n, 51);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hold_edge_cnt", 32'(edge_cnt), 32'd1);
        check("abort_hold_span", 32'(span), 32'd0);
        repeat (4) step();

        push_exp(25, 96, 96);
        run_window(-1, 30, -1, n);
        check("ign_start_gate_len", n, GATE);
        step();
        check("ign_start_idle", 32'(busy), 32'd0);
        repeat (3) step();

        push_exp(25, 96, 96);
        push_exp(25, 96, 96);
        d0 = done_at.size();
        run_window(-1, -1, -1, n);
        check("b2b_first_len", n, GATE);
        run_window(-1, -1, -1, n);
        check("b2b_second_len", n, GATE);
        step();
        check("b2b_done_count", done_at.size() - d0, 2);
        if (done_at.size() - d0 == 2)
            check("b2b_spacing", done_at[d0 + 1] - done_at[d0], GATE + 1);

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        rst = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("mrst_span", 32'(span), 32'd0);
        repeat (3) step();
        rst = 1'b1;
        repeat (8) step();
        push_exp(25, 96, 96);
        run_window(-1, -1, -1, n);
        check("post_rst_gate_len", n, GATE);
        repeat (5) step();
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule
